// File: rtl/bayesian_imc_scheduler.sv
// ---------------------------------------------------------------------------
// bayesian_imc_scheduler
// Job-issuing front end for the Bayesian IMC core. Host requests are queued,
// issued to the core one at a time with operands held stable for the whole
// job, and the core's mean/confidence is returned on a valid/ready port. A
// watchdog ends jobs whose done pulse never arrives and latches a sticky fault.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   req_valid/req_ready           host request handshake
//   req_data/weight_sel/conf/tag  request payload
//   core_start                    one-cycle start pulse to the core
//   core_input_data/weight_select/confidence_pattern  held job operands
//   core_done/core_mean/core_confidence  core completion pulse and result
//   res_valid/res_ready           result handshake
//   res_mean/confidence/tag       captured result
//   res_confident (comb)          res_confidence >= CONF_THRESH
//   res_timeout                   job ended by the watchdog
//   fault                         sticky watchdog flag, cleared by rst only
//   busy (comb)                   FSM active or queue non-empty
//   jobs_done                     count of non-timeout results handed off
// ---------------------------------------------------------------------------
module bayesian_imc_scheduler #(
  parameter int unsigned WORD_SIZE   = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT     = 63,
  parameter int unsigned CONF_THRESH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WORD_SIZE-1:0] req_data,
  input  logic [1:0]           req_weight_sel,
  input  logic [WORD_SIZE-1:0] req_conf,
  input  logic [2:0]           req_tag,
  output logic                 core_start,
  output logic [WORD_SIZE-1:0] core_input_data,
  output logic [1:0]           core_weight_select,
  output logic [WORD_SIZE-1:0] core_confidence_pattern,
  input  logic                 core_done,
  input  logic [3:0]           core_mean,
  input  logic [3:0]           core_confidence,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [3:0]           res_mean,
  output logic [3:0]           res_confidence,
  output logic [2:0]           res_tag,
  output logic                 res_confident,
  output logic                 res_timeout,
  output logic                 fault,
  output logic                 busy,
  output logic [7:0]           jobs_done
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [TMR_W-1:0] TMR_MAX   = {TMR_W{1'b1}};
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_RESULT = 2'd3;

  typedef struct packed {
    logic [WORD_SIZE-1:0] data;
    logic [1:0]           weight_sel;
    logic [WORD_SIZE-1:0] conf;
    logic [2:0]           tag;
  } req_entry_t;

  // Request queue storage and bookkeeping
  req_entry_t       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  req_entry_t       head;
  req_entry_t       wr_entry;

  // FSM and registered-output next values
  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [TMR_W-1:0]     timer_q;
  logic [TMR_W-1:0]     timer_d;
  logic [TMR_W-1:0]     timer_inc;
  logic                 start_d;
  logic [WORD_SIZE-1:0] data_d;
  logic [1:0]           sel_d;
  logic [WORD_SIZE-1:0] pat_d;
  logic [2:0]           tag_d;
  logic                 rvalid_d;
  logic [3:0]           mean_d;
  logic [3:0]           rconf_d;
  logic                 rtimeout_d;
  logic                 fault_d;
  logic [7:0]           jobs_d;

  // Queue push side: no pass-through, the FSM only ever reads the head
  assign req_ready = (count < CNT_FULL) && !fault;
  assign push      = req_valid && req_ready;
  assign head      = mem[rd_ptr];

  always_comb begin
    wr_entry            = '0;
    wr_entry.data       = req_data;
    wr_entry.weight_sel = req_weight_sel;
    wr_entry.conf       = req_conf;
    wr_entry.tag        = req_tag;
  end

  // Queue payload storage; contents are don't-care while not counted
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Queue pointers and occupancy; simultaneous push and pop keep the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Watchdog timer saturates so it can never wrap back below the limit
  assign timer_inc = (timer_q == TMR_MAX) ? timer_q : timer_q + TMR_W'(1);

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    start_d    = 1'b0;
    data_d     = core_input_data;
    sel_d      = core_weight_select;
    pat_d      = core_confidence_pattern;
    tag_d      = res_tag;
    rvalid_d   = res_valid;
    mean_d     = res_mean;
    rconf_d    = res_confidence;
    rtimeout_d = res_timeout;
    fault_d    = fault;
    jobs_d     = jobs_done;
    pop        = 1'b0;

    case (state_q)
      S_IDLE: begin
        // A latched fault freezes issue; queued entries wait for reset
        if ((count != '0) && !fault) begin
          pop     = 1'b1;
          data_d  = head.data;
          sel_d   = head.weight_sel;
          pat_d   = head.conf;
          tag_d   = head.tag;
          start_d = 1'b1;
          timer_d = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end

      S_WAIT: begin
        timer_d = timer_inc;
        // A done pulse in the same cycle as the limit still wins
        if (core_done) begin
          mean_d     = core_mean;
          rconf_d    = core_confidence;
          rtimeout_d = 1'b0;
          rvalid_d   = 1'b1;
          state_d    = S_RESULT;
        end else if (timer_inc == TMR_LIMIT) begin
          mean_d     = 4'd0;
          rconf_d    = 4'd0;
          rtimeout_d = 1'b1;
          rvalid_d   = 1'b1;
          fault_d    = 1'b1;
          state_d    = S_RESULT;
        end
      end

      S_RESULT: begin
        if (res_ready) begin
          rvalid_d = 1'b0;
          if (!res_timeout) begin
            jobs_d = jobs_done + 8'd1;
          end
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q                 <= S_IDLE;
      timer_q                 <= '0;
      core_start              <= 1'b0;
      core_input_data         <= '0;
      core_weight_select      <= '0;
      core_confidence_pattern <= '0;
      res_tag                 <= '0;
      res_valid               <= 1'b0;
      res_mean                <= '0;
      res_confidence          <= '0;
      res_timeout             <= 1'b0;
      fault                   <= 1'b0;
      jobs_done               <= '0;
    end else begin
      state_q                 <= state_d;
      timer_q                 <= timer_d;
      core_start              <= start_d;
      core_input_data         <= data_d;
      core_weight_select      <= sel_d;
      core_confidence_pattern <= pat_d;
      res_tag                 <= tag_d;
      res_valid               <= rvalid_d;
      res_mean                <= mean_d;
      res_confidence          <= rconf_d;
      res_timeout             <= rtimeout_d;
      fault                   <= fault_d;
      jobs_done               <= jobs_d;
    end
  end

  // Combinational status outputs derived from registers only
  assign res_confident = (32'(res_confidence) >= CONF_THRESH);
  assign busy          = (state_q != S_IDLE) || (count != '0);

endmodule

// File: tb/tb_bayesian_imc_scheduler.sv
// Directed bench for bayesian_imc_scheduler with a behavioural core model.
module tb_bayesian_imc_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_data;
  logic [1:0] req_weight_sel;
  logic [7:0] req_conf;
  logic [2:0] req_tag;
  logic       core_start;
  logic [7:0] core_input_data;
  logic [1:0] core_weight_select;
  logic [7:0] core_confidence_pattern;
  logic       core_done;
  logic [3:0] core_mean;
  logic [3:0] core_confidence;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_mean;
  logic [3:0] res_confidence;
  logic [2:0] res_tag;
  logic       res_confident;
  logic       res_timeout;
  logic       fault;
  logic       busy;
  logic [7:0] jobs_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bayesian_imc_scheduler dut (
    .clk                     (clk),
    .rst                     (rst),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_data                (req_data),
    .req_weight_sel          (req_weight_sel),
    .req_conf                (req_conf),
    .req_tag                 (req_tag),
    .core_start              (core_start),
    .core_input_data         (core_input_data),
    .core_weight_select      (core_weight_select),
    .core_confidence_pattern (core_confidence_pattern),
    .core_done               (core_done),
    .core_mean               (core_mean),
    .core_confidence         (core_confidence),
    .res_valid               (res_valid),
    .res_ready               (res_ready),
    .res_mean                (res_mean),
    .res_confidence          (res_confidence),
    .res_tag                 (res_tag),
    .res_confident           (res_confident),
    .res_timeout             (res_timeout),
    .fault                   (fault),
    .busy                    (busy),
    .jobs_done               (jobs_done)
  );

  // Core model: done is seen in the 42nd cycle after the start cycle
  int         m_cnt      = 0;
  logic       model_done = 1'b0;
  logic       spur_done  = 1'b0;
  logic       model_en   = 1'b1;
  logic       mode_echo  = 1'b0;
  logic [3:0] fix_mean   = 4'd0;
  logic [3:0] fix_conf   = 4'd0;
  logic [3:0] m_mean     = 4'd0;
  logic [3:0] m_conf     = 4'd0;

  assign core_done       = model_done | spur_done;
  assign core_mean       = m_mean;
  assign core_confidence = m_conf;

  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      m_cnt      = 0;
      model_done = 1'b0;
    end else begin
      model_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0 && model_en) model_done = 1'b1;
      end
      if (core_start) begin
        m_cnt  = 42;
        m_mean = mode_echo ? core_input_data[3:0] : fix_mean;
        m_conf = mode_echo ? core_confidence_pattern[3:0] : fix_conf;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d, input logic [1:0] s, input logic [7:0] c,
                      input logic [2:0] t);
    req_valid      = 1'b1;
    req_data       = d;
    req_weight_sel = s;
    req_conf       = c;
    req_tag        = t;
    step();
    req_valid      = 1'b0;
  endtask

  // Bounded wait for res_valid; reports the cycle seen and core_start pulses met
  task automatic wait_res(input int limit, output int at, output int starts);
    int n;
    n      = 0;
    starts = 0;
    while (res_valid !== 1'b1 && n < limit) begin
      if (core_start === 1'b1) starts++;
      step();
      n++;
    end
    at = cyc;
    chk("res_valid_wait", res_valid, 1);
  endtask

  initial begin
    int t0;
    int at;
    int prev;
    int st;

    rst            = 1'b1;
    req_valid      = 1'b0;
    req_data       = '0;
    req_weight_sel = '0;
    req_conf       = '0;
    req_tag        = '0;
    res_ready      = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_core_start", core_start, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_jobs_done", jobs_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    step();

    // Single job with fixed core result 7/15
    mode_echo = 1'b0;
    fix_mean  = 4'd7;
    fix_conf  = 4'd15;
    t0 = cyc;
    push(8'hFF, 2'd2, 8'h00, 3'd5);
    chk("t1_start_c1", core_start, 0);
    step();
    chk("t1_start_c2", core_start, 1);
    chk("t1_data", core_input_data, 8'hFF);
    chk("t1_sel", core_weight_select, 2);
    chk("t1_pat", core_confidence_pattern, 8'h00);
    step();
    chk("t1_start_c3", core_start, 0);
    wait_res(100, at, st);
    chk("t1_extra_starts", st, 0);
    chk("t1_latency", at - t0, 45);
    chk("t1_mean", res_mean, 7);
    chk("t1_conf", res_confidence, 15);
    chk("t1_confident", res_confident, 1);
    chk("t1_tag", res_tag, 5);
    chk("t1_timeout", res_timeout, 0);
    step();
    chk("t1_valid_drop", res_valid, 0);
    chk("t1_jobs_done", jobs_done, 1);

    // Queue fill while a job runs, then in-order completion at 45-cycle period
    mode_echo = 1'b1;
    t0 = cyc;
    push(8'hA0, 2'd0, 8'h06, 3'd0);
    repeat (3) step();
    for (int j = 1; j <= 4; j++) begin
      chk("t2_ready_before_push", req_ready, 1);
      push(8'hA0 | 8'(j), 2'(j), 8'(6 + j), 3'(j));
    end
    chk("t2_full", req_ready, 0);
    chk("t2_busy", busy, 1);
    prev = t0;
    for (int j = 0; j <= 4; j++) begin
      wait_res(100, at, st);
      chk("t2_period", at - prev, 45);
      chk("t2_tag", res_tag, j);
      chk("t2_mean", res_mean, j);
      chk("t2_conf", res_confidence, 6 + j);
      chk("t2_confident", res_confident, (6 + j) >= 8);
      prev = at;
      step();
    end
    chk("t2_jobs_done", jobs_done, 6);

    // Result back-pressure for 20 cycles
    res_ready = 1'b0;
    t0 = cyc;
    push(8'h3C, 2'd1, 8'h0B, 3'd6);
    push(8'h55, 2'd3, 8'h02, 3'd7);
    wait_res(100, at, st);
    chk("t3_latency", at - t0, 45);
    for (int k = 0; k < 20; k++) begin
      chk("t3_hold_valid", res_valid, 1);
      chk("t3_hold_tag", res_tag, 6);
      chk("t3_hold_mean", res_mean, 12);
      chk("t3_hold_conf", res_confidence, 11);
      chk("t3_hold_data", core_input_data, 8'h3C);
      chk("t3_hold_sel", core_weight_select, 1);
      chk("t3_no_start", core_start, 0);
      step();
    end
    chk("t3_queue_ready", req_ready, 1);
    res_ready = 1'b1;
    step();
    chk("t3_release_valid", res_valid, 0);
    chk("t3_release_idle_start", core_start, 0);
    step();
    chk("t3_next_issue", core_start, 1);
    chk("t3_next_data", core_input_data, 8'h55);
    wait_res(100, at, st);
    chk("t3_tag7", res_tag, 7);
    chk("t3_mean7", res_mean, 5);
    chk("t3_conf7", res_confidence, 2);
    chk("t3_confident7", res_confident, 0);
    step();
    chk("t3_jobs_done", jobs_done, 8);

    // Spurious done while idle
    spur_done = 1'b1;
    step();
    spur_done = 1'b0;
    repeat (2) step();
    chk("t4_spur_valid", res_valid, 0);
    chk("t4_spur_busy", busy, 0);
    chk("t4_spur_jobs", jobs_done, 8);
    chk("t4_spur_start", core_start, 0);

    // Watchdog timeout with a second entry left queued
    model_en  = 1'b0;
    res_ready = 1'b0;
    t0 = cyc;
    push(8'h11, 2'd0, 8'hFF, 3'd3);
    repeat (4) step();
    push(8'h22, 2'd1, 8'h0F, 3'd4);
    wait_res(100, at, st);
    chk("t5_latency", at - t0, 66);
    chk("t5_timeout", res_timeout, 1);
    chk("t5_mean", res_mean, 0);
    chk("t5_conf", res_confidence, 0);
    chk("t5_confident", res_confident, 0);
    chk("t5_tag", res_tag, 3);
    chk("t5_fault", fault, 1);
    chk("t5_req_ready", req_ready, 0);
    chk("t5_jobs_hold", jobs_done, 8);
    res_ready = 1'b1;
    step();
    chk("t5_valid_drop", res_valid, 0);
    chk("t5_jobs_after", jobs_done, 8);
    for (int k = 0; k < 10; k++) begin
      chk("t5_no_issue", core_start, 0);
      step();
    end
    chk("t5_busy_queued", busy, 1);
    chk("t5_fault_sticky", fault, 1);
    chk("t5_ready_blocked", req_ready, 0);

    // Reset clears fault and queue
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("t6_fault_clr", fault, 0);
    chk("t6_busy_clr", busy, 0);
    chk("t6_ready", req_ready, 1);
    chk("t6_jobs_clr", jobs_done, 0);

    // Build up jobs_done, then reset in WAIT cycle 20
    model_en  = 1'b1;
    mode_echo = 1'b0;
    fix_mean  = 4'd9;
    fix_conf  = 4'd3;
    t0 = cyc;
    push(8'h42, 2'd2, 8'h80, 3'd2);
    wait_res(100, at, st);
    step();
    chk("t6_pre_jobs", jobs_done, 1);
    t0 = cyc;
    push(8'h43, 2'd3, 8'h81, 3'd6);
    while (cyc < t0 + 22) step();
    chk("t6_wait_busy", busy, 1);
    chk("t6_wait_data", core_input_data, 8'h43);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_data", core_input_data, 0);
    chk("t6_async_sel", core_weight_select, 0);
    chk("t6_async_pat", core_confidence_pattern, 0);
    chk("t6_async_tag", res_tag, 0);
    chk("t6_async_valid", res_valid, 0);
    chk("t6_async_jobs", jobs_done, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ready", req_ready, 1);
    step();
    step();
    rst = 1'b0;
    step();
    repeat (30) begin
      chk("t6_no_result_after_abort", res_valid, 0);
      step();
    end
    t0 = cyc;
    push(8'h01, 2'd0, 8'h00, 3'd1);
    wait_res(100, at, st);
    chk("t6_latency", at - t0, 45);
    chk("t6_mean", res_mean, 9);
    chk("t6_conf", res_confidence, 3);
    chk("t6_confident", res_confident, 0);
    chk("t6_tag", res_tag, 1);
    step();
    chk("t6_jobs_done", jobs_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard against a stuck run
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
